gyro_spi_ctrl: RTL and testbench

Transaction sequencer for the PmodGYRO (L3G4200D) that drives the byte-level SPI engine (spi_interface, mode 3). After power-up it writes CTRL_REG1 once, then periodically burst-reads OUT_X_L..OUT_Z_H. It assembles three signed 16-bit axis samples and presents them to downstream logic with a one-cycle valid strobe. It owns slave_select, send_data and begin_transmission, and consumes recieved_data and end_transmission.

---
 rtl/gyro_pkg.sv | 30 +++
 rtl/cycle_timer.sv | 30 +++
 rtl/gyro_spi_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_gyro_spi_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gyro_pkg.sv
// Shared definitions for the PmodGYRO (L3G4200D) SPI transaction sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gyro_pkg;

  typedef enum logic [3:0] {
    ST_STARTUP,
    ST_CFG_SS,
    ST_CFG_ADDR,
    ST_CFG_DATA,
    ST_GAP,
    ST_IDLE_WAIT,
    ST_RD_SS,
    ST_RD_ADDR,
    ST_RD_BYTE,
    ST_RD_DONE
  } state_t;

  // L3G4200D register map and SPI command bits
  localparam logic [7:0] CTRL_REG1  = 8'h20;
  localparam logic [7:0] OUT_X_L    = 8'h28;
  localparam logic [7:0] SPI_READ   = 8'h80;
  localparam logic [7:0] SPI_MULTI  = 8'h40;
  localparam logic [7:0] RD_CMD     = SPI_READ | SPI_MULTI | OUT_X_L;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;

  // XL, XH, YL, YH, ZL, ZH
  localparam int NUM_DATA_BYTES = 6;

endpackage

// File: rtl/cycle_timer.sv
// Loadable up-counter with a terminal-count flag against a run-time limit.
// Latency: tc is combinational from the count register; clr/inc act on the next edge.
// Backpressure: none; the owner decides each cycle whether to clear or count.
//   clk, rst (async, active-low), clr, inc, limit -> tc (count == limit)
module cycle_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/gyro_spi_ctrl.sv
// Sequencer for the L3G4200D: writes CTRL_REG1 once, then periodically burst-reads X/Y/Z.
// Latency: one SPI byte per begin/end handshake; axes publish one cycle after the last byte.
// Backpressure: waits on end_transmission per byte; a byte stuck past TIMEOUT_CYCLES aborts the frame.
//   in : clk, rst (async active-low), enable, recieved_data[7:0], end_transmission
//   out: send_data[7:0], begin_transmission, slave_select, x/y/z_axis[15:0], data_valid, busy, timeout_err
module gyro_spi_ctrl
  import gyro_pkg::*;
#(
  parameter logic [23:0] STARTUP_CYCLES = 24'd1_000_000,
  parameter logic [23:0] POLL_CYCLES    = 24'd1_000_000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'h20000,
  parameter logic [7:0]  SS_GAP_CYCLES  = 8'd16,
  parameter logic [7:0]  CFG_REG1       = 8'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  recieved_data,
  input  logic        end_transmission,
  output logic [7:0]  send_data,
  output logic        begin_transmission,
  output logic        slave_select,
  output logic [15:0] x_axis,
  output logic [15:0] y_axis,
  output logic [15:0] z_axis,
  output logic        data_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DATA_BYTES - 1);

  state_t                             state;
  logic                               waiting;   // 0: send phase of a byte state, 1: wait phase
  logic                               cfg_done;
  logic                               et_q;
  logic [2:0]                         byte_idx;
  logic [NUM_DATA_BYTES-1:0][7:0]     rx_buf;
  logic [7:0]                         tx_byte;
  logic                               byte_done;
  logic                               tmr_clr;
  logic                               tmr_inc;
  logic                               tmr_tc;
  logic [23:0]                        tmr_limit;

  // Byte complete = rising edge of end_transmission seen while waiting
  assign byte_done = waiting & end_transmission & ~et_q;
  assign busy      = (state != ST_IDLE_WAIT);

  always_comb begin
    case (state)
      ST_CFG_ADDR: tx_byte = CTRL_REG1;
      ST_CFG_DATA: tx_byte = CFG_REG1;
      ST_RD_ADDR:  tx_byte = RD_CMD;
      default:     tx_byte = DUMMY_BYTE;
    endcase
  end

  // One shared timer; the limit it is compared against depends on the state
  always_comb begin
    case (state)
      ST_STARTUP:   tmr_limit = STARTUP_CYCLES - 24'd1;
      ST_GAP:       tmr_limit = {16'd0, SS_GAP_CYCLES} - 24'd1;
      ST_IDLE_WAIT: tmr_limit = POLL_CYCLES - 24'd1;
      default:      tmr_limit = {4'd0, TIMEOUT_CYCLES};
    endcase
  end

  // Every state exit clears the timer, so each state starts counting from 0.
  // Byte states clear it in the send phase (the begin_transmission cycle).
  always_comb begin
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    case (state)
      ST_STARTUP, ST_GAP: begin
        tmr_clr = tmr_tc;
        tmr_inc = ~tmr_tc;
      end
      ST_IDLE_WAIT: begin
        tmr_clr = ~enable | tmr_tc;
        tmr_inc = enable & ~tmr_tc;
      end
      ST_CFG_ADDR, ST_CFG_DATA, ST_RD_ADDR, ST_RD_BYTE: begin
        tmr_clr = ~waiting | byte_done | tmr_tc;
        tmr_inc = waiting & ~byte_done & ~tmr_tc;
      end
      default: tmr_clr = 1'b1;
    endcase
  end

  cycle_timer #(.W(24)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_STARTUP;
      waiting            <= 1'b0;
      cfg_done           <= 1'b0;
      et_q               <= 1'b1;
      byte_idx           <= '0;
      rx_buf             <= '0;
      send_data          <= 8'h00;
      begin_transmission <= 1'b0;
      slave_select       <= 1'b1;
      x_axis             <= '0;
      y_axis             <= '0;
      z_axis             <= '0;
      data_valid         <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      et_q               <= end_transmission;
      begin_transmission <= 1'b0;
      data_valid         <= 1'b0;
      case (state)
        ST_STARTUP: begin
          if (tmr_tc) begin
            state        <= ST_CFG_SS;
            slave_select <= 1'b0;
          end
        end
        ST_CFG_SS: begin
          slave_select <= 1'b0;
          state        <= ST_CFG_ADDR;
        end
        ST_CFG_ADDR, ST_CFG_DATA, ST_RD_ADDR, ST_RD_BYTE: begin
          if (!waiting) begin
            send_data          <= tx_byte;
            begin_transmission <= 1'b1;
            waiting            <= 1'b1;
          end else if (byte_done) begin
            // Done is tested before the timeout so a same-cycle edge is accepted
            waiting <= 1'b0;
            case (state)
              ST_CFG_ADDR: state <= ST_CFG_DATA;
              ST_CFG_DATA: begin
                slave_select <= 1'b1;
                cfg_done     <= 1'b1;
                state        <= ST_GAP;
              end
              ST_RD_ADDR: begin
                byte_idx <= '0;
                state    <= ST_RD_BYTE;
              end
              default: begin
                rx_buf[byte_idx] <= recieved_data;
                if (byte_idx == LAST_IDX) begin
                  state <= ST_RD_DONE;
                end else begin
                  byte_idx <= byte_idx + 3'd1;
                end
              end
            endcase
          end else if (tmr_tc) begin
            waiting      <= 1'b0;
            timeout_err  <= 1'b1;
            slave_select <= 1'b1;
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_tc) begin
            if (cfg_done) begin
              state <= ST_IDLE_WAIT;
            end else begin
              state        <= ST_CFG_SS;
              slave_select <= 1'b0;
            end
          end
        end
        ST_IDLE_WAIT: begin
          if (enable && tmr_tc) begin
            state        <= ST_RD_SS;
            slave_select <= 1'b0;
          end
        end
        ST_RD_SS: begin
          slave_select <= 1'b0;
          state        <= ST_RD_ADDR;
        end
        ST_RD_DONE: begin
          slave_select <= 1'b1;
          x_axis       <= {rx_buf[1], rx_buf[0]};
          y_axis       <= {rx_buf[3], rx_buf[2]};
          z_axis       <= {rx_buf[5], rx_buf[4]};
          data_valid   <= 1'b1;
          state        <= ST_GAP;
        end
        default: begin
          slave_select <= 1'b1;
          state        <= ST_STARTUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gyro_spi_ctrl.sv
// Self-checking bench for gyro_spi_ctrl: SPI slave model with per-byte delay/data plan,
// frame-level reference model of the expected command bytes and assembled axis values.
// Covers startup/config, fixed and random frames, timeout, enable drop and mid-frame reset.
module tb_gyro_spi_ctrl;

  localparam int STARTUP = 4;
  localparam int POLL    = 50;
  localparam int TIMEOUT = 200;
  localparam int SS_GAP  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  recieved_data = 8'h00;
  logic        end_transmission = 1'b1;
  logic [7:0]  send_data;
  logic        begin_transmission;
  logic        slave_select;
  logic [15:0] x_axis, y_axis, z_axis;
  logic        data_valid;
  logic        busy;
  logic        timeout_err;

  gyro_spi_ctrl #(
    .STARTUP_CYCLES (24'(STARTUP)),
    .POLL_CYCLES    (24'(POLL)),
    .TIMEOUT_CYCLES (20'(TIMEOUT)),
    .SS_GAP_CYCLES  (8'(SS_GAP)),
    .CFG_REG1       (8'h0F)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .recieved_data      (recieved_data),
    .end_transmission   (end_transmission),
    .send_data          (send_data),
    .begin_transmission (begin_transmission),
    .slave_select       (slave_select),
    .x_axis             (x_axis),
    .y_axis             (y_axis),
    .z_axis             (z_axis),
    .data_valid         (data_valid),
    .busy               (busy),
    .timeout_err        (timeout_err)
  );

  initial forever #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_begin = 0;
  int          beg_cyc = 0;
  int          n_dv = 0;
  int          dv_base = 0;
  int          tx_base = 0;
  logic [7:0]  tx_log[$];
  int          plan_dly[$];          // per-byte completion delay in cycles, -1 = never completes
  logic [7:0]  plan_dat[$];
  logic [15:0] dv_x, dv_y, dv_z;
  logic [15:0] exp_x = '0, exp_y = '0, exp_z = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    if (tx_base + i < tx_log.size()) return tx_log[tx_base + i];
    return 8'hxx;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI engine model: end_transmission drops after begin, rises d edges later with the byte
  initial begin
    int         dly;
    int         n;
    logic [7:0] dat;
    logic       prev_ss;
    prev_ss = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (begin_transmission) begin
        check_eq("ss_low_before_begin", {31'd0, prev_ss}, 0);
        check_eq("ss_low_at_begin", {31'd0, slave_select}, 0);
        tx_log.push_back(send_data);
        n_begin++;
        beg_cyc = cyc;
        if (plan_dly.size() > 0) begin
          dly = plan_dly.pop_front();
          dat = plan_dat.pop_front();
        end else begin
          dly = 10;
          dat = 8'h00;
        end
        end_transmission = 1'b0;
        @(posedge clk); #1;
        check_eq("begin_one_cycle", {31'd0, begin_transmission}, 0);
        if (dly < 0) begin
          n = 0;
          while (slave_select == 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
          end
        end else begin
          repeat (dly - 1) @(posedge clk);
          #1;
        end
        recieved_data    = dat;
        end_transmission = 1'b1;
      end
      prev_ss = slave_select;
    end
  end

  // data_valid monitor: latch published axes, require single-cycle pulses
  initial begin
    logic prev_dv;
    prev_dv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (data_valid) begin
        check_eq("dv_single_cycle", {31'd0, prev_dv}, 0);
        dv_x = x_axis;
        dv_y = y_axis;
        dv_z = z_axis;
        n_dv++;
      end
      prev_dv = data_valid;
    end
  end

  // slave_select must stay high for at least SS_GAP cycles between frames
  initial begin
    int run;
    run = 0;
    forever begin
      @(posedge clk); #1;
      if (slave_select) begin
        run++;
      end else begin
        if (run > 0) check_eq("ss_gap_min", {31'd0, run >= SS_GAP}, 1);
        run = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "bench stalled");
  end

  task automatic load_frame(input logic [5:0][7:0] b, input int slow_k, input int slow_d);
    plan_dly.delete();
    plan_dat.delete();
    tx_base = tx_log.size();
    dv_base = n_dv;
    plan_dly.push_back($urandom_range(1, 20));
    plan_dat.push_back(8'($urandom));        // returned during the address byte, discarded
    for (int k = 0; k < 6; k++) begin
      plan_dly.push_back(k == slow_k ? slow_d : $urandom_range(1, 20));
      plan_dat.push_back(b[k]);
    end
  endtask

  task automatic expect_frame(input logic [5:0][7:0] b);
    int n;
    n = 0;
    while (n_dv == dv_base && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("frame_published", n_dv - dv_base, 1);
    exp_x = {b[1], b[0]};
    exp_y = {b[3], b[2]};
    exp_z = {b[5], b[4]};
    check_eq("x_axis", {16'd0, dv_x}, {16'd0, exp_x});
    check_eq("y_axis", {16'd0, dv_y}, {16'd0, exp_y});
    check_eq("z_axis", {16'd0, dv_z}, {16'd0, exp_z});
    check_eq("rd_len", tx_log.size() - tx_base, 7);
    check_eq("rd_cmd", {24'd0, log_at(0)}, 32'hE8);
    for (int i = 1; i < 7; i++) check_eq("rd_dummy", {24'd0, log_at(i)}, 0);
    check_eq("busy_in_frame", {31'd0, busy}, 1);
  endtask

  task automatic startup_and_config();
    int n;
    tx_base = tx_log.size();
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (slave_select && n < 100);
    check_eq("startup_cycles", n, STARTUP);
    n = 0;
    while (!slave_select && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("cfg_ss_release", {31'd0, slave_select}, 1);
    check_eq("cfg_len", tx_log.size() - tx_base, 2);
    check_eq("cfg_addr", {24'd0, log_at(0)}, 32'h20);
    check_eq("cfg_data", {24'd0, log_at(1)}, 32'h0F);
  endtask

  task automatic wait_begins(input int target);
    int n;
    n = 0;
    while (n_begin < target && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("begin_reached", {31'd0, n_begin >= target}, 1);
  endtask

  initial begin
    logic [5:0][7:0] b;
    int              n;
    int              base;

    rst    = 1'b0;
    enable = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ss", {31'd0, slave_select}, 1);
    check_eq("rst_begin", {31'd0, begin_transmission}, 0);
    check_eq("rst_send", {24'd0, send_data}, 0);
    check_eq("rst_axes", {16'd0, x_axis | y_axis | z_axis}, 0);
    check_eq("rst_dv", {31'd0, data_valid}, 0);
    check_eq("rst_terr", {31'd0, timeout_err}, 0);
    check_eq("rst_busy", {31'd0, busy}, 1);

    // Startup and configuration
    startup_and_config();

    // Fixed read frame
    b = {8'h9A, 8'hBC, 8'h56, 8'h78, 8'h12, 8'h34};
    load_frame(b, -1, 0);
    expect_frame(b);

    // Random frames
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
      load_frame(b, -1, 0);
      expect_frame(b);
    end

    // End edge seen on the very cycle the timeout count is reached: byte accepted
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    load_frame(b, 2, TIMEOUT);
    expect_frame(b);
    check_eq("same_cycle_no_err", {31'd0, timeout_err}, 0);

    // Byte k=2 never completes: frame aborted, axes untouched
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    base = n_begin;
    load_frame(b, 2, -1);
    wait_begins(base + 4);
    n = 0;
    while (!slave_select && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    // counter is 0 on the first wait edge and reaches TIMEOUT on wait edge TIMEOUT+1
    check_eq("timeout_cycles", cyc - beg_cyc, TIMEOUT + 1);
    check_eq("timeout_err_set", {31'd0, timeout_err}, 1);
    check_eq("timeout_no_dv", n_dv - dv_base, 0);
    check_eq("timeout_x_kept", {16'd0, x_axis}, {16'd0, exp_x});
    check_eq("timeout_y_kept", {16'd0, y_axis}, {16'd0, exp_y});
    check_eq("timeout_z_kept", {16'd0, z_axis}, {16'd0, exp_z});
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    load_frame(b, -1, 0);
    expect_frame(b);
    check_eq("timeout_err_sticky", {31'd0, timeout_err}, 1);

    // enable drops during byte k=3: frame still completes, then no new frame
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    base = n_begin;
    load_frame(b, -1, 0);
    wait_begins(base + 5);
    enable = 1'b0;
    expect_frame(b);
    n = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (!slave_select) n++;
    end
    check_eq("no_frame_disabled", n, 0);
    check_eq("idle_not_busy", {31'd0, busy}, 0);
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    load_frame(b, -1, 0);
    enable = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (slave_select && n < 1000);
    check_eq("poll_cycles", n, POLL);
    expect_frame(b);

    // Reset during byte k=4
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    base = n_begin;
    load_frame(b, -1, 0);
    wait_begins(base + 6);
    rst = 1'b0;
    #1;
    check_eq("midrst_ss", {31'd0, slave_select}, 1);
    check_eq("midrst_x", {16'd0, x_axis}, 0);
    check_eq("midrst_y", {16'd0, y_axis}, 0);
    check_eq("midrst_z", {16'd0, z_axis}, 0);
    check_eq("midrst_terr", {31'd0, timeout_err}, 0);
    repeat (20) @(posedge clk);
    plan_dly.delete();
    plan_dat.delete();
    startup_and_config();
    check_eq("post_rst_no_dv", n_dv - dv_base, 0);
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    load_frame(b, -1, 0);
    expect_frame(b);
    check_eq("final_terr", {31'd0, timeout_err}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
